// File: rtl/bbs_sequencer.sv
// Blum-Blum-Shub random bit sequencer.
// Each step computes x(n+1) = x(n)^2 mod MOD with a bit-serial interleaved
// modular multiplier, spending SIZE cycles per square plus one emit cycle.
// The LSB of every new x is packed into an OUT_BITS word, which is offered
// on a valid/ready handshake. While a word waits for the consumer the
// generator is frozen.
module bbs_sequencer #(
    parameter int SIZE     = 16,
    parameter int MOD      = 40633,
    parameter int OUT_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                seed_valid,
    input  logic [SIZE-1:0]     seed_in,
    output logic                seed_err,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_BITS-1:0] out_data,
    output logic                busy
);

    localparam int                CNT_W    = $clog2(OUT_BITS + 1);
    localparam int                IDX_W    = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [SIZE:0]     MOD_W    = (SIZE + 1)'(MOD);
    localparam logic [IDX_W-1:0]  IDX_TOP  = IDX_W'(SIZE - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(OUT_BITS);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_EMIT, S_HOLD} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [SIZE-1:0]       r_x;
    logic [SIZE-1:0]       r_acc;
    logic [IDX_W-1:0]      r_idx;
    logic [CNT_W-1:0]      r_cnt;
    logic [OUT_BITS-1:0]   r_pack;
    logic [OUT_BITS-1:0]   r_out_data;
    logic                  r_out_valid;
    logic                  r_seed_err;
    logic                  w_busy;

    logic                  w_seed_ok;
    logic                  w_seed_bad;
    logic                  w_xfer;
    logic                  w_mul_last;
    logic                  w_word_done;
    logic [CNT_W-1:0]      w_cnt_inc;
    logic [OUT_BITS-1:0]   w_pack_nxt;

    // One multiplier step, MSB first: acc = 2*acc mod MOD, then add x if the
    // current multiplier bit is set. acc < MOD always holds, so each partial
    // result stays below 2*MOD and one conditional subtraction is enough.
    function automatic logic [SIZE-1:0] mod_step(input logic [SIZE-1:0] acc,
                                                 input logic [SIZE-1:0] x,
                                                 input logic            mbit);
        logic [SIZE:0] t;
        t = {acc, 1'b0};
        if (t >= MOD_W) t = t - MOD_W;
        if (mbit) begin
            t = t + {1'b0, x};
            if (t >= MOD_W) t = t - MOD_W;
        end
        return t[SIZE-1:0];
    endfunction

    assign w_seed_ok   = seed_valid && ({1'b0, seed_in} <  MOD_W);
    assign w_seed_bad  = seed_valid && ({1'b0, seed_in} >= MOD_W);
    assign w_xfer      = r_out_valid && out_ready;
    assign w_mul_last  = (r_idx == '0);
    assign w_cnt_inc   = r_cnt + 1'b1;
    assign w_word_done = (w_cnt_inc >= CNT_FULL);
    assign w_pack_nxt  = {r_pack[OUT_BITS-2:0], r_acc[0]};

    assign seed_err  = r_seed_err;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign busy      = w_busy;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state and busy decode; a valid seed overrides every state.
    always_comb begin
        w_state_nxt = r_state;
        w_busy      = (r_state == S_MUL) || (r_state == S_EMIT);
        if (w_seed_ok) begin
            w_state_nxt = S_MUL;
        end else begin
            case (r_state)
                S_IDLE: w_state_nxt = S_IDLE;
                S_MUL:  if (w_mul_last) w_state_nxt = S_EMIT;
                S_EMIT: w_state_nxt = w_word_done ? S_HOLD : S_MUL;
                S_HOLD: if (w_xfer) w_state_nxt = S_MUL;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Datapath: seed load, squaring, bit packing and output handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_x         <= '0;
            r_acc       <= '0;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_pack      <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_seed_err  <= 1'b0;
        end else begin
            r_seed_err <= w_seed_bad;
            if (w_seed_ok) begin
                r_x         <= seed_in;
                r_acc       <= '0;
                r_idx       <= IDX_TOP;
                r_cnt       <= '0;
                r_pack      <= '0;
                r_out_valid <= 1'b0;
            end else begin
                case (r_state)
                    S_MUL: begin
                        r_acc <= mod_step(r_acc, r_x, r_x[r_idx]);
                        if (!w_mul_last) r_idx <= r_idx - 1'b1;
                    end
                    S_EMIT: begin
                        r_x    <= r_acc;
                        r_pack <= w_pack_nxt;
                        r_cnt  <= w_cnt_inc;
                        r_acc  <= '0;
                        r_idx  <= IDX_TOP;
                        if (w_word_done) begin
                            r_out_data  <= w_pack_nxt;
                            r_out_valid <= 1'b1;
                        end
                    end
                    S_HOLD: begin
                        if (w_xfer) begin
                            r_out_valid <= 1'b0;
                            r_cnt       <= '0;
                            r_pack      <= '0;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bbs_sequencer.sv
// Testbench for bbs_sequencer: directed scenarios plus randomized traffic,
// all checked every cycle against a word-level BBS reference model.
module tb_bbs_sequencer;

    localparam int SIZE = 16;
    localparam int MOD  = 40633;
    localparam int OB   = 8;
    localparam int WORD_CYC = OB * (SIZE + 1);

    logic            clk;
    logic            reset;
    logic            seed_valid;
    logic [SIZE-1:0] seed_in;
    logic            seed_err;
    logic            out_valid;
    logic            out_ready;
    logic [OB-1:0]   out_data;
    logic            busy;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state: seeded?, word waiting?, cycles into current word.
    logic          m_active;
    logic          m_hold;
    logic          m_err;
    int            m_t;
    longint        m_x;
    logic [OB-1:0] m_word;

    bbs_sequencer #(.SIZE(SIZE), .MOD(MOD), .OUT_BITS(OB)) dut (
        .clk        (clk),
        .reset      (reset),
        .seed_valid (seed_valid),
        .seed_in    (seed_in),
        .seed_err   (seed_err),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Advance the model by one clock edge using the inputs applied for it.
    task automatic model_update();
        logic [OB-1:0] w;
        if (!reset) begin
            m_active = 1'b0; m_hold = 1'b0; m_err = 1'b0; m_t = 0; m_x = 0;
            return;
        end
        m_err = seed_valid && (int'(seed_in) >= MOD);
        if (seed_valid && int'(seed_in) < MOD) begin
            m_active = 1'b1; m_hold = 1'b0; m_t = 0; m_x = longint'(seed_in);
        end else if (m_hold) begin
            if (out_ready) begin m_hold = 1'b0; m_t = 0; end
        end else if (m_active) begin
            m_t++;
            if (m_t == WORD_CYC) begin
                w = '0;
                for (int k = 0; k < OB; k++) begin
                    m_x = (m_x * m_x) % MOD;
                    w = {w[OB-2:0], m_x[0]};
                end
                m_word = w;
                m_hold = 1'b1;
            end
        end
    endtask

    task automatic compare();
        chk("out_valid", 32'(out_valid), 32'(m_hold));
        chk("busy", 32'(busy), 32'(m_active && !m_hold));
        chk("seed_err", 32'(seed_err), 32'(m_err));
        if (m_hold) chk("out_data", 32'(out_data), 32'(m_word));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare();
    endtask

    task automatic load_seed(input int v);
        seed_valid = 1'b1;
        seed_in    = SIZE'(v);
        cycle();
        seed_valid = 1'b0;
    endtask

    task automatic wait_valid(input int bound, output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < bound) begin
            cycle();
            n++;
        end
    endtask

    initial begin
        int n;
        int r;
        m_active = 1'b0; m_hold = 1'b0; m_err = 1'b0; m_t = 0; m_x = 0; m_word = '0;
        reset = 1'b0; seed_valid = 1'b0; seed_in = '0; out_ready = 1'b1;
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(seed_err), 32'd0);
        for (int i = 0; i < 3; i++) cycle();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) cycle();

        // Out-of-range seeds are rejected from IDLE.
        load_seed(MOD);
        cycle();
        load_seed(65535);
        for (int i = 0; i < 5; i++) cycle();

        // Seed 3, consumer always ready.
        out_ready = 1'b1;
        load_seed(3);
        wait_valid(300, n);
        chk("lat_seed3", 32'(n), 32'(WORD_CYC));
        chk("word_seed3", 32'(out_data), 32'h0E5);
        cycle();

        // Seed 3, consumer stalls for 50 cycles.
        out_ready = 1'b0;
        load_seed(3);
        wait_valid(300, n);
        chk("lat_stall", 32'(n), 32'(WORD_CYC));
        for (int i = 0; i < 50; i++) begin
            cycle();
            chk("stall_data", 32'(out_data), 32'h0E5);
            chk("stall_busy", 32'(busy), 32'd0);
        end
        load_seed(65535);
        chk("hold_rej_data", 32'(out_data), 32'h0E5);
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        wait_valid(300, n);
        chk("lat_next", 32'(n), 32'(WORD_CYC));
        out_ready = 1'b1;
        cycle();

        // Seed 5 aborts seed 3 partway through the fifth bit.
        load_seed(3);
        for (int i = 0; i < 69; i++) cycle();
        load_seed(5);
        wait_valid(300, n);
        chk("lat_abort", 32'(n), 32'(WORD_CYC));
        cycle();

        // Asynchronous reset in the middle of a square.
        load_seed(3);
        for (int i = 0; i < 40; i++) cycle();
        #1 reset = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_data", 32'(out_data), 32'd0);
        cycle();
        reset = 1'b1;
        for (int i = 0; i < 200; i++) cycle();

        // Seed 0 gives all-zero words at a steady cadence.
        out_ready = 1'b1;
        load_seed(0);
        for (int w = 0; w < 3; w++) begin
            wait_valid(300, n);
            chk("lat_zero", 32'(n), 32'(WORD_CYC));
            chk("word_zero", 32'(out_data), 32'd0);
            cycle();
        end

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            out_ready  = ($urandom_range(0, 9) < 7);
            seed_valid = 1'b0;
            r = int'($urandom_range(0, 399));
            if (r == 0 || (r == 2 && m_hold)) begin
                seed_valid = 1'b1;
                seed_in    = SIZE'($urandom_range(0, MOD - 1));
            end else if (r == 1 && (!m_active || (m_hold && !out_ready))) begin
                seed_valid = 1'b1;
                seed_in    = SIZE'($urandom_range(MOD, 65535));
            end
            cycle();
        end
        seed_valid = 1'b0;
        for (int i = 0; i < 5; i++) cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
